// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   MD_OP_W   width of the md_op field
//   MD_OP_*   operation encodings presented on md_op
//   md_state_t FSM states of md_unit (IDLE, RUN)
package md_pkg;

    localparam int unsigned MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_OP_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_OP_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_OP_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_OP_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_OP_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational multiply/divide datapath.
//   md_op        operation (mult/multu/div/divu; others give zero)
//   a, b         operands (rs, rt)
//   res_hi       HI result (product high half or remainder)
//   res_lo       LO result (product low half or quotient)
//   div_by_zero  high for div/divu with b == 0; results must not be written
module md_calc
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo,
    output logic               div_by_zero
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [2*WIDTH-1:0] s_prod;
    logic        [2*WIDTH-1:0] u_prod;
    logic        [WIDTH-1:0]   s_div_b;
    logic        [WIDTH-1:0]   u_div_b;
    logic signed [WIDTH-1:0]   s_quo;
    logic signed [WIDTH-1:0]   s_rem;
    logic        [WIDTH-1:0]   u_quo;
    logic        [WIDTH-1:0]   u_rem;
    logic                      s_ovf;

    always_comb begin
        s_prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        u_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

        // Divisors are steered to 1 for the zero and MIN_INT/-1 cases so the
        // dividers never see an undefined operation; those results are
        // replaced or discarded below.
        s_ovf   = (a == MIN_INT) && (b == '1);
        s_div_b = ((b == '0) || s_ovf) ? ONE : b;
        u_div_b = (b == '0) ? ONE : b;

        s_quo = $signed(a) / $signed(s_div_b);
        s_rem = $signed(a) % $signed(s_div_b);
        u_quo = a / u_div_b;
        u_rem = a % u_div_b;

        res_hi = '0;
        res_lo = '0;
        case (md_op)
            MD_OP_MULT:  {res_hi, res_lo} = s_prod;
            MD_OP_MULTU: {res_hi, res_lo} = u_prod;
            MD_OP_DIV: begin
                if (s_ovf) begin
                    res_hi = '0;
                    res_lo = MIN_INT;
                end else begin
                    res_hi = s_rem;
                    res_lo = s_quo;
                end
            end
            MD_OP_DIVU: begin
                res_hi = u_rem;
                res_lo = u_quo;
            end
            default: ;
        endcase

        div_by_zero = (b == '0) && ((md_op == MD_OP_DIV) || (md_op == MD_OP_DIVU));
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning the HI/LO registers.
// Optional feature: define MDU_CANCEL_EN to add the `cancel` input, which
// aborts an in-flight operation and blocks a start in the same cycle.
//   clk     system clock, rising edge
//   reset   synchronous active-low reset
//   start   md/mt operation valid (sampled only when idle)
//   md_op   operation encoding (see md_pkg)
//   a, b    rs / rt operands
//   mf_sel  0 selects LO, 1 selects HI onto rdata
//   cancel  (MDU_CANCEL_EN only) abort / block acceptance
//   busy    registered, high while mult/div is in flight
//   hi, lo  current HI / LO registers
//   rdata   mf_sel ? hi : lo
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mf_sel,
`ifdef MDU_CANCEL_EN
    input  logic               cancel,
`endif
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   rdata
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    md_state_t          state;
    logic [CNT_W-1:0]   counter;
    logic [MD_OP_W-1:0] op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               div_by_zero;
    logic               cancel_req;

`ifdef MDU_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    // The datapath works on latched operands so a/b may change while busy.
    md_calc #(
        .WIDTH(WIDTH)
    ) u_calc (
        .md_op       (op_q),
        .a           (a_q),
        .b           (b_q),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !cancel_req) begin
                        case (md_op)
                            MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                                op_q    <= md_op;
                                a_q     <= a;
                                b_q     <= b;
                                counter <= ((md_op == MD_OP_DIV) || (md_op == MD_OP_DIVU))
                                           ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            MD_OP_MTHI: hi <= a;
                            MD_OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cancel_req) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        counter <= '0;
                    end else if (counter == CNT_W'(1)) begin
                        if (!div_by_zero) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        state   <= IDLE;
                        busy    <= 1'b0;
                        counter <= '0;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    counter <= '0;
                end
            endcase
        end
    end

    assign rdata = mf_sel ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int unsigned W     = 32;
    localparam int          MLAT  = 5;
    localparam int          DLAT  = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    md_op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          mf_sel;
`ifdef MDU_CANCEL_EN
    logic          cancel;
`endif
    logic          busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  rdata;

    int            n_checks;
    int            n_errors;
    logic [63:0]   exp_q[$];
    logic [63:0]   m_hilo;

    md_unit #(
        .WIDTH       (W),
        .MULT_CYCLES (MLAT),
        .DIV_CYCLES  (DLAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .mf_sel (mf_sel),
`ifdef MDU_CANCEL_EN
        .cancel (cancel),
`endif
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one operation given the current {hi,lo}.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] cur);
        longint             sx, sy;
        logic [63:0]        ux, uy;
        logic signed [31:0] qx, qy;
        logic signed [31:0] q, r;
        case (op)
            3'd0: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                return 64'(sx * sy);
            end
            3'd1: begin
                ux = {32'h0, x};
                uy = {32'h0, y};
                return ux * uy;
            end
            3'd2: begin
                if (y == 32'h0) return cur;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                qx = x;
                qy = y;
                q  = qx / qy;
                r  = qx % qy;
                return {r, q};
            end
            3'd3: begin
                if (y == 32'h0) return cur;
                return {x % y, x / y};
            end
            3'd4:    return {x, cur[31:0]};
            3'd5:    return {cur[63:32], x};
            default: return cur;
        endcase
    endfunction

    // Called at a negedge; presents the op for one rising edge and returns
    // at the following negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit commit);
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
        if (commit) begin
            m_hilo = model(op, x, y, m_hilo);
            exp_q.push_back(m_hilo);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles (bounded); optionally keeps an mtlo request asserted
    // while busy, which must be ignored.
    task automatic wait_done(input string tag, input int lat, input bit hold_mt);
        int n;
        n = 0;
        while (busy && n < 200) begin
            if (hold_mt) begin
                start = 1'b1;
                md_op = 3'd5;
                a     = 32'h5;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check(tag, 64'(n), 64'(lat));
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            check(tag, {hi, lo}, exp_q.pop_front());
        end
    endtask

    function automatic int lat_of(input logic [2:0] op);
        return (op < 3'd2) ? MLAT : DLAT;
    endfunction

    initial begin
        logic [63:0] saved;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        n_checks = 0;
        n_errors = 0;
        reset  = 1'b0;
        start  = 1'b0;
        md_op  = '0;
        a      = '0;
        b      = '0;
        mf_sel = 1'b0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        m_hilo = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // mult signed: -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_done("mult_busy", MLAT, 1'b0);
        pop_check("mult");
        check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // multu, issued in the first cycle after completion
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_done("multu_busy", MLAT, 1'b0);
        pop_check("multu");
        check("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        // div signed: -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("div_busy", DLAT, 1'b0);
        pop_check("div");
        check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // mthi / mtlo then divu by zero
        issue(3'd4, 32'h11, 32'h0, 1'b1);
        wait_done("mthi_busy", 0, 1'b0);
        pop_check("mthi");
        issue(3'd5, 32'h22, 32'h0, 1'b1);
        wait_done("mtlo_busy", 0, 1'b0);
        pop_check("mtlo");
        issue(3'd3, 32'h1234, 32'h0, 1'b1);
        wait_done("divu0_busy", DLAT, 1'b0);
        pop_check("divu0");
        check("divu0_const", {hi, lo}, 64'h0000_0011_0000_0022);
        mf_sel = 1'b1;
        #1 check("rdata_hi", 64'(rdata), 64'h11);
        mf_sel = 1'b0;
        #1 check("rdata_lo", 64'(rdata), 64'h22);

        // signed overflow MIN_INT / -1
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("ovf_busy", DLAT, 1'b0);
        pop_check("div_ovf");
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        // signed div with negative divisor: 7 / -2 -> q=-3, r=1
        issue(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done("divn_busy", DLAT, 1'b0);
        pop_check("div_neg_b");
        check("div_neg_b_const", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        // ops 6/7 do nothing
        saved = {hi, lo};
        issue(3'd6, 32'hDEAD, 32'hBEEF, 1'b0);
        check("op6_busy", 64'(busy), 64'd0);
        issue(3'd7, 32'hDEAD, 32'hBEEF, 1'b0);
        check("op7_hilo", {hi, lo}, saved);

        // start while busy is ignored
        issue(3'd0, 32'h0001_0003, 32'h0002_0005, 1'b1);
        wait_done("ign_busy", MLAT, 1'b1);
        pop_check("ign_start");

        // random mult/div traffic
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 2) ? 32'($urandom_range(0, 9)) : $urandom;
            issue(rop, ra, rb, 1'b1);
            wait_done("rnd_busy", lat_of(rop), 1'b0);
            pop_check("rnd");
        end

        // mult, mtlo while busy, then reset mid-flight
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd5;
        a     = 32'h5;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        m_hilo = '0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        repeat (DLAT) @(negedge clk);
        check("no_late_wb", {hi, lo}, 64'd0);
        check("no_late_busy", 64'(busy), 64'd0);

`ifdef MDU_CANCEL_EN
        issue(3'd4, 32'hA5A5_0001, 32'h0, 1'b1);
        pop_check("pre_cancel_mthi");
        saved = {hi, lo};
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_hilo", {hi, lo}, saved);
        issue(3'd0, 32'hFFFF_FFF0, 32'd16, 1'b1);
        wait_done("post_cancel_busy", MLAT, 1'b0);
        pop_check("post_cancel_mult");
        saved = {hi, lo};
        cancel = 1'b1;
        issue(3'd1, 32'd9, 32'd9, 1'b0);
        cancel = 1'b0;
        check("cancel_blk_busy", 64'(busy), 64'd0);
        repeat (MLAT + 1) @(negedge clk);
        check("cancel_blk_hilo", {hi, lo}, saved);
`endif

        if (exp_q.size() != 0) check("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
